// File: rtl/gb_pkg.sv
// Shared Game Boy bus constants and the OAM DMA state encoding.
// Used by oam_dma; the start delay itself is selected by OAM_DMA_START_DELAY_EN.
package gb_pkg;

   localparam logic [15:0] DMA_REG_ADDR    = 16'hFF46;
   localparam logic [15:0] OAM_BASE        = 16'hFE00;
   localparam int unsigned OAM_BYTES       = 160;
   localparam logic [7:0]  ECHO_PAGE_START = 8'hE0;
   localparam logic [7:0]  ECHO_OFFSET     = 8'h20;

   typedef enum logic [1:0] {
      IDLE,
      START,
      XFER
   } dma_state_t;

   // Pages E0..FF alias work RAM C0..DF (echo RAM).
   function automatic logic [7:0] src_page(input logic [7:0] page);
      return (page >= ECHO_PAGE_START) ? (page - ECHO_OFFSET) : page;
   endfunction

endpackage

// File: rtl/oam_dma.sv
// Game Boy OAM DMA: copies 160 bytes from page {FF46,00} into OAM at FE00.
// Define OAM_DMA_START_DELAY_EN to insert the DMG one-M-cycle start delay.
module oam_dma
   import gb_pkg::*;
#(
   parameter int unsigned CLKS_PER_MCYCLE = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_w,
   input  logic        cpu_write_enable,
   output logic [7:0]  cpu_data_r,
   output logic        dma_active,
   output logic [15:0] dma_addr,
   input  logic [7:0]  dma_data_r,
   output logic [7:0]  dma_data_w,
   output logic        dma_write_enable
);

   localparam int unsigned        PHASE_W    = $clog2(CLKS_PER_MCYCLE);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLKS_PER_MCYCLE - 1);
   localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
   localparam logic [7:0]         INDEX_LAST = 8'(OAM_BYTES - 1);

`ifdef OAM_DMA_START_DELAY_EN
   localparam dma_state_t TRIG_STATE = START;
`else
   localparam dma_state_t TRIG_STATE = XFER;
`endif

   dma_state_t         r_state;
   logic [7:0]         r_page;
   logic [7:0]         r_index;
   logic [PHASE_W-1:0] r_phase;
   logic [7:0]         r_byte_q;
   logic [15:0]        r_dma_addr;
   logic               r_dma_we;

   dma_state_t         w_state;
   logic [7:0]         w_page;
   logic [7:0]         w_index;
   logic [PHASE_W-1:0] w_phase;
   logic               w_trigger;
   logic [15:0]        w_src_addr;

   always_comb begin
      w_trigger  = cpu_write_enable && (cpu_addr == DMA_REG_ADDR);
      w_page     = w_trigger ? cpu_data_w : r_page;
      w_state    = r_state;
      w_index    = r_index;
      w_phase    = r_phase;
      if (w_trigger) begin
         w_state = TRIG_STATE;
         w_index = '0;
         w_phase = '0;
      end else begin
         case (r_state)
            START: begin
               if (r_phase == PHASE_LAST) begin
                  w_state = XFER;
                  w_phase = '0;
               end else begin
                  w_phase = r_phase + PHASE_ONE;
               end
            end
            XFER: begin
               if (r_phase == PHASE_LAST) begin
                  w_phase = '0;
                  if (r_index == INDEX_LAST) begin
                     w_state = IDLE;
                     w_index = '0;
                  end else begin
                     w_index = r_index + 8'd1;
                  end
               end else begin
                  w_phase = r_phase + PHASE_ONE;
               end
            end
            default: ;
         endcase
      end
      w_src_addr = {src_page(w_page), w_index};
   end

   // Bus outputs are registered from the next-state values so they line up
   // with the phase that state occupies.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_page     <= 8'hFF;
         r_index    <= '0;
         r_phase    <= '0;
         r_byte_q   <= '0;
         r_dma_addr <= '0;
         r_dma_we   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_page  <= w_page;
         r_index <= w_index;
         r_phase <= w_phase;
         if ((r_state == XFER) && (r_phase == '0)) begin
            r_byte_q <= dma_data_r;
         end
         r_dma_we <= (w_state == XFER) && (w_phase == PHASE_ONE);
         if (w_state == XFER) begin
            r_dma_addr <= (w_phase == '0) ? w_src_addr : (OAM_BASE + {8'h00, w_index});
         end else begin
            r_dma_addr <= '0;
         end
      end
   end

   assign cpu_data_r       = r_page;
   assign dma_active       = (r_state != IDLE);
   assign dma_addr         = r_dma_addr;
   assign dma_data_w       = r_byte_q;
   assign dma_write_enable = r_dma_we;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected OAM writes are queued at trigger time
// and popped by a negedge monitor that also models work RAM and OAM.
module tb_oam_dma;

`ifdef OAM_DMA_START_DELAY_EN
   localparam int DLY = 1;
   localparam int N   = 4;
`else
   localparam int DLY = 0;
   localparam int N   = 2;
`endif
   localparam int ACTIVE    = (160 + DLY) * N;
   localparam int FIRST_LAT = DLY * N + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_w;
   logic        cpu_write_enable;
   logic [7:0]  cpu_data_r;
   logic        dma_active;
   logic [15:0] dma_addr;
   logic [7:0]  dma_data_r;
   logic [7:0]  dma_data_w;
   logic        dma_write_enable;

   always #5 clk = ~clk;

   oam_dma #(.CLKS_PER_MCYCLE(N)) dut (
      .clk              (clk),
      .reset            (reset),
      .cpu_addr         (cpu_addr),
      .cpu_data_w       (cpu_data_w),
      .cpu_write_enable (cpu_write_enable),
      .cpu_data_r       (cpu_data_r),
      .dma_active       (dma_active),
      .dma_addr         (dma_addr),
      .dma_data_r       (dma_data_r),
      .dma_data_w       (dma_data_w),
      .dma_write_enable (dma_write_enable)
   );

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic [7:0] ram [0:65535];
   logic [7:0] oam [0:159];
   wr_t        exp_q [$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pulses = 0, act_cnt = 0, low_cnt = 0;
   int first_wr = -1, last_wr = -1, gap_bad = 0, rd_cnt = 0, rd_bad = 0;
   bit gap_en = 1'b0;
   logic [7:0] exp_src = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Work RAM returns data on negedge for the address presented that cycle.
   always @(negedge clk) dma_data_r <= ram[dma_addr];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Page C0..C6 contents: C1 holds i^5A, other pages differ by a page-dependent XOR.
   function automatic logic [7:0] pat(input logic [7:0] pg, input int i);
      return 8'(i) ^ 8'h5A ^ (pg ^ 8'hC1);
   endfunction

   function automatic int oam_bad(input logic [7:0] pg, input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) if (oam[i] !== pat(pg, i)) n++;
      return n;
   endfunction

   always @(negedge clk) begin
      wr_t e;
      if (dma_active) act_cnt++; else low_cnt++;
      if (dma_active && !dma_write_enable && dma_addr != 16'h0000 && dma_addr[15:8] != 8'hFE) begin
         rd_cnt++;
         if (dma_addr[15:8] != exp_src) rd_bad++;
      end
      if (dma_write_enable) begin
         pulses++;
         if (first_wr < 0) first_wr = cyc;
         if (gap_en && last_wr >= 0 && (cyc - last_wr) != N) gap_bad++;
         last_wr = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", dma_addr, dma_data_w);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", dma_addr, e.addr);
            chk("wr_data", dma_data_w, e.data);
         end
         if (dma_addr >= 16'hFE00 && dma_addr < 16'hFEA0) oam[int'(dma_addr - 16'hFE00)] = dma_data_w;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] srcpg);
      wr_t e;
      for (int i = 0; i < 160; i++) begin
         e.addr = 16'hFE00 + 16'(i);
         e.data = pat(srcpg, i);
         exp_q.push_back(e);
      end
   endtask

   // Drives an FF46 write for one edge; t is the cycle count seen at negedges
   // of the period following the sampling edge.
   task automatic ff46(input logic [7:0] pg, output int t);
      cpu_addr         = 16'hFF46;
      cpu_data_w       = pg;
      cpu_write_enable = 1'b1;
      t = cyc + 1;
      tick();
      cpu_write_enable = 1'b0;
      cpu_addr         = 16'h0000;
      cpu_data_w       = 8'h00;
   endtask

   task automatic wait_pulses(input int target, input string name);
      int n = 0;
      while (pulses < target && n < 4 * ACTIVE) begin tick(); n++; end
      if (pulses < target) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got %0d pulses expected %0d", name, pulses, target);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (dma_active && n < 4 * ACTIVE) begin tick(); n++; end
      if (dma_active) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got dma_active 1 expected 0", name);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int t, t2, base;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      for (int p = 8'hC0; p <= 8'hC6; p++)
         for (int i = 0; i < 256; i++) ram[{8'(p), 8'(i)}] = pat(8'(p), i);
      for (int i = 0; i < 256; i++) ram[{8'hE2, 8'(i)}] = 8'h77;
      for (int i = 0; i < 160; i++) oam[i] = 8'hEE;

      reset = 1'b1; cpu_addr = '0; cpu_data_w = '0; cpu_write_enable = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_active", dma_active, 0);
      chk("rst_addr", dma_addr, 16'h0000);
      chk("rst_we", dma_write_enable, 0);
      chk("rst_data_w", dma_data_w, 8'h00);
      chk("rst_cpu_data_r", cpu_data_r, 8'hFF);

      // Plain transfer from C1
      act_cnt = 0; first_wr = -1; last_wr = -1; gap_bad = 0; gap_en = 1'b1;
      rd_cnt = 0; rd_bad = 0; exp_src = 8'hC1; base = pulses;
      push_exp(8'hC1);
      ff46(8'hC1, t);
      wait_idle("c1");
      tick();
      chk("c1_active_len", act_cnt, ACTIVE);
      chk("c1_first_wr_lat", first_wr - t, FIRST_LAT);
      chk("c1_pulses", pulses - base, 160);
      chk("c1_gap_bad", gap_bad, 0);
      chk("c1_reads", rd_cnt, 160);
      chk("c1_read_page_bad", rd_bad, 0);
      chk("c1_queue_left", exp_q.size(), 0);
      chk("c1_oam_bad", oam_bad(8'hC1, 0, 159), 0);
      chk("idle_addr", dma_addr, 16'h0000);
      chk("idle_we", dma_write_enable, 0);

      // Echo page E2 must read C2
      rd_cnt = 0; rd_bad = 0; exp_src = 8'hC2; base = pulses; last_wr = -1; gap_bad = 0;
      push_exp(8'hC2);
      ff46(8'hE2, t);
      chk("echo_cpu_data_r", cpu_data_r, 8'hE2);
      wait_idle("echo");
      tick();
      chk("echo_pulses", pulses - base, 160);
      chk("echo_reads", rd_cnt, 160);
      chk("echo_read_page_bad", rd_bad, 0);
      chk("echo_gap_bad", gap_bad, 0);
      chk("echo_oam_bad", oam_bad(8'hC2, 0, 159), 0);
      chk("echo_queue_left", exp_q.size(), 0);

      // Restart after 50 bytes
      gap_en = 1'b0; base = pulses;
      push_exp(8'hC0);
      ff46(8'hC0, t);
      wait_pulses(base + 50, "restart50");
      exp_q.delete();
      push_exp(8'hC3);
      ff46(8'hC3, t);
      wait_idle("restart");
      tick();
      chk("restart_pulses", pulses - base, 210);
      chk("restart_oam_bad", oam_bad(8'hC3, 0, 159), 0);
      chk("restart_queue_left", exp_q.size(), 0);

      // Reset during byte 80
      base = pulses;
      push_exp(8'hC4);
      ff46(8'hC4, t);
      wait_pulses(base + 80, "rst80");
      reset = 1'b1;
      tick();
      chk("midrst_active", dma_active, 0);
      chk("midrst_we", dma_write_enable, 0);
      chk("midrst_cpu_data_r", cpu_data_r, 8'hFF);
      exp_q.delete();
      reset = 1'b0;
      repeat (4 * N) tick();
      chk("midrst_pulses", pulses - base, 80);
      chk("midrst_oam_head_bad", oam_bad(8'hC4, 0, 79), 0);
      chk("midrst_oam_tail_bad", oam_bad(8'hC3, 80, 159), 0);

      // FF46 write on the final edge of byte 159
      base = pulses; act_cnt = 0;
      push_exp(8'hC5);
      ff46(8'hC5, t);
      while (cyc < t + ACTIVE - 1) tick();
      low_cnt = 0;
      push_exp(8'hC6);
      ff46(8'hC6, t2);
      wait_idle("coincident");
      chk("coin_active_gap", low_cnt, 0);
      tick();
      chk("coin_active_len", act_cnt, 2 * ACTIVE);
      chk("coin_pulses", pulses - base, 320);
      chk("coin_oam_bad", oam_bad(8'hC6, 0, 159), 0);
      chk("coin_queue_left", exp_q.size(), 0);
      chk("coin_cpu_data_r", cpu_data_r, 8'hC6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
